uart_rx_oversampler: RTL and testbench
======================================

# uart_rx_oversampler

Parametrised UART receive-side oversampler: generates the oversample tick from the system clock, detects the start bit, and recovers each serial bit with a 3-sample majority vote at mid-bit. It sits between the raw `rx` pin and the UART RX shift/frame logic, replacing the fixed single-rate oversampling clock generator. Oversample ratio is run-time selectable (8/16/32), and the baud divider is programmable.

## Interface
- `DIV_W`, 16: width of the `baud_div` input.
- `FRAME_BITS`, 10: bits per frame including start and stop; legal range is 3..16.
- `clk` input, 1 bit: system clock.
- `rst_n` input, 1 bit: reset, asynchronous and active-low.
- `en` input, 1 bit: block enable.
- `prescale` input, 2 bits: oversample ratio N.
  - 0 selects 8, 1 selects 16, 2 selects 32.
  - 3 is reserved and behaves as 16.
- `baud_div` input, `DIV_W` bits: system clocks per oversample tick, minus 1.
- `rx` input, 1 bit: asynchronous serial line; idles high.
- `tick` output, 1 bit: one-clk oversample tick strobe.
- `bit_valid` output, 1 bit: one-clk strobe for each recovered data bit.
- `bit_val` output, 1 bit: recovered data bit, qualified by `bit_valid`.
- `frame_done` output, 1 bit: one-clk strobe after the stop bit is sampled.
- `frame_err` output, 1 bit: one-clk strobe; stop bit was sampled as 0 (coincident with `frame_done`).
- `start_err` output, 1 bit: one-clk strobe; false start was detected.
- `busy` output, 1 bit: high in every state except IDLE.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer to give `rx_s`; both flops reset to 1.
- **Divider:**
  - `div_cnt` counts 0..`baud_div` while `en` is high.
  - `tick` is high for the clk in which `div_cnt == baud_div`; `div_cnt` then wraps to 0.
  - With `baud_div` = 0, `tick` is asserted every clk.
- **Latched parameters:** N is latched into `n_lat` on start detect, so a `prescale` change mid-frame has no effect until the next frame.
- **Counters:**
  - `ovs_cnt` is 5 bits and counts ticks within a bit, 0..N-1, then wraps to 0.
  - `bit_cnt` is `$clog2(FRAME_BITS)` bits.
- **Sample window:** samples are taken at `ovs_cnt` = N/2-1, N/2 and N/2+1 and shifted into a 3-bit register. The decision is the majority of the three, evaluated at N/2+1.
- **FSM states:** IDLE, START, DATA, STOP.
  - **IDLE:** on a `tick` with `rx_s`=0, go to START, with `ovs_cnt`=1 and `bit_cnt`=0.
  - **START:**
    - Decision = 1: pulse `start_err`, go to IDLE.
    - Decision = 0: continue, and go to DATA when `ovs_cnt` wraps.
  - **DATA:**
    - Each decision drives `bit_val` and pulses `bit_valid`.
    - `bit_cnt` increments at each wrap.
    - After FRAME_BITS-2 bits, go to STOP.
  - **STOP:** the decision pulses `frame_done`, plus `frame_err` if the decision is 0; go to IDLE immediately, without waiting for the wrap.
- **`en` low:** next clk, go to IDLE and clear all counters and the sample register. No strobes are issued. The synchronizer keeps running.
- **Reset:** all outputs are 0, the FSM is in IDLE, and all counters are 0. Reset mid-frame abandons the frame with no strobes.
- **Simultaneous events:** `en` falling on a decision tick suppresses that decision's strobe.

## Timing
- `tick` is combinational from the registered `div_cnt` compare. All other outputs are registered.
- Latency from the decision tick (`ovs_cnt`=N/2+1) to `bit_valid`, `frame_done`, `frame_err` or `start_err`: 1 clk.
- Start-detect uncertainty is 1 tick, plus 2 clk of synchronizer delay.
- One bit period is N×(`baud_div`+1) clk.
- The first data-bit decision occurs (N + N/2+1) ticks after start detect.

## Configuration
- **`OVS_MAJORITY_EN` defined:** the decision is the 3-sample majority vote, so a single-tick glitch is rejected.
- **`OVS_MAJORITY_EN` undefined:** the decision is the single sample at N/2, with the strobe timing unchanged (decision still registered at the N/2+1 tick). The 3-bit sample register is omitted.

## Structure
- **Shared package `uart_pkg`:**
  - Prescale encoding constants (`OVS_X8`, `OVS_X16`, `OVS_X32`).
  - FSM state enum.
  - A function mapping prescale to N.
- **Sub-module `ovs_tick_gen`:** `div_cnt` plus the `tick` compare, with `clk`, `rst_n`, `en`, `baud_div` and `tick` ports. It is reused by the TX side.

## Test plan
- **Basic frame:** `baud_div`=3, `prescale`=1 (64 clk/bit); send 0x55 8N1 -> 8 `bit_valid` pulses LSB first with `bit_val` 1,0,1,0,1,0,1,0, spaced 64 clk apart; then `frame_done`=1 with `frame_err`=0.
- **False start:** `rx` low for 3 ticks, then high -> `start_err` pulses once and `busy` falls; no `bit_valid`.
- **Bad stop bit:** stop bit driven 0 -> `frame_done` and `frame_err` are both asserted in the same clk.
- **Glitch rejection:** `prescale`=0, 0xFF with a 1-tick low glitch at `ovs_cnt`=N/2 of bit 3.
  - With `OVS_MAJORITY_EN` -> `bit_val`=1.
  - Without it -> `bit_val`=0.
- **Ratio change:** `prescale`=2 with `baud_div`=0 (32 clk/bit) receives 0xA3 correctly; `prescale` changed to 0 mid-frame -> frame still decoded at ×32.
- **Reset/disable mid-frame:** `rst_n` asserted, or `en` dropped, at data bit 4 -> all outputs 0 and the FSM in IDLE; the next frame 0x3C is decoded correctly.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: prescale encodings, receive FSM states and
// the prescale-to-oversample-ratio mapping used by the RX and TX sides.
package uart_pkg;

  localparam logic [1:0] OVS_X8  = 2'd0;
  localparam logic [1:0] OVS_X16 = 2'd1;
  localparam logic [1:0] OVS_X32 = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } ovs_state_e;

  // The reserved encoding 3 falls into the default and runs at x16.
  function automatic logic [5:0] ovs_ratio(input logic [1:0] prescale);
    case (prescale)
      OVS_X8:  return 6'd8;
      OVS_X16: return 6'd16;
      OVS_X32: return 6'd32;
      default: return 6'd16;
    endcase
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/ovs_tick_gen.sv
// Programmable oversample tick generator: one tick every baud_div+1 clocks
// while enabled; the counter is held at zero while disabled.
module ovs_tick_gen #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [DIV_W-1:0] baud_div,
  output logic             tick
);

  logic [DIV_W-1:0] div_cnt_q;
  logic [DIV_W-1:0] div_cnt_d;
  logic             hit;

  assign hit  = (div_cnt_q == baud_div);
  assign tick = en & hit;

  always_comb begin
    div_cnt_d = div_cnt_q;
    if (!en) begin
      div_cnt_d = '0;
    end else if (hit) begin
      div_cnt_d = '0;
    end else begin
      div_cnt_d = div_cnt_q + {{(DIV_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_oversampler.sv
// UART RX oversampler: start detect and mid-bit recovery at x8/x16/x32.
// Define OVS_MAJORITY_EN for a 3-sample majority decision; otherwise the mid sample decides.
module uart_rx_oversampler
  import uart_pkg::*;
#(
  parameter int DIV_W      = 16,
  parameter int FRAME_BITS = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       prescale,
  input  logic [DIV_W-1:0] baud_div,
  input  logic             rx,
  output logic             tick,
  output logic             bit_valid,
  output logic             bit_val,
  output logic             frame_done,
  output logic             frame_err,
  output logic             start_err,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int BIT_W = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(FRAME_BITS - 3);
  localparam logic [BIT_W-1:0] BIT_ONE   = BIT_W'(1);

  ovs_state_e       state_q;
  logic             rx_meta_q, rx_s_q;
  logic [4:0]       ovs_cnt_q;
  logic [BIT_W-1:0] bit_cnt_q;
  logic [5:0]       n_lat_q;
  logic             bit_valid_q, bit_val_q, frame_done_q, frame_err_q, start_err_q;
  logic [5:0]       ovs6, half6, dec6, last6;
  logic             at_dec, at_last, active, decision;
  logic [4:0]       ovs_next;

  ovs_tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .baud_div (baud_div),
    .tick     (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  assign ovs6     = {1'b0, ovs_cnt_q};
  assign half6    = n_lat_q >> 1;
  assign dec6     = half6 + 6'd1;
  assign last6    = n_lat_q - 6'd1;
  assign at_dec   = (ovs6 == dec6);
  assign at_last  = (ovs6 == last6);
  assign active   = (state_q != ST_IDLE);
  assign ovs_next = at_last ? 5'd0 : ovs_cnt_q + 5'd1;

`ifdef OVS_MAJORITY_EN
  // Holds the N/2-1 and N/2 samples; the N/2+1 sample is taken live from rx_s_q.
  logic [1:0] samp_q;
  logic [5:0] pre6;
  logic       samp_hit;
  assign pre6     = half6 - 6'd1;
  assign samp_hit = active && ((ovs6 == pre6) || (ovs6 == half6) || at_dec);
  always_comb begin
    decision = maj3(samp_q[1], samp_q[0], rx_s_q);
  end
`else
  logic samp_mid_q;
  logic samp_hit;
  assign samp_hit = active && (ovs6 == half6);
  always_comb begin
    decision = samp_mid_q;
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ovs_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      n_lat_q      <= 6'd16;
`ifdef OVS_MAJORITY_EN
      samp_q       <= '0;
`else
      samp_mid_q   <= 1'b0;
`endif
      bit_valid_q  <= 1'b0;
      bit_val_q    <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      start_err_q  <= 1'b0;
    end else begin
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      start_err_q  <= 1'b0;
      if (!en) begin
        // Disable wins over any decision landing in the same clock.
        state_q    <= ST_IDLE;
        ovs_cnt_q  <= '0;
        bit_cnt_q  <= '0;
        bit_val_q  <= 1'b0;
`ifdef OVS_MAJORITY_EN
        samp_q     <= '0;
`else
        samp_mid_q <= 1'b0;
`endif
      end else if (tick) begin
        if (samp_hit) begin
`ifdef OVS_MAJORITY_EN
          samp_q <= {samp_q[0], rx_s_q};
`else
          samp_mid_q <= rx_s_q;
`endif
        end
        case (state_q)
          ST_IDLE: begin
            if (!rx_s_q) begin
              state_q   <= ST_START;
              ovs_cnt_q <= 5'd1;
              bit_cnt_q <= '0;
              n_lat_q   <= ovs_ratio(prescale);
            end
          end
          ST_START: begin
            if (at_dec && decision) begin
              start_err_q <= 1'b1;
              state_q     <= ST_IDLE;
              ovs_cnt_q   <= '0;
            end else begin
              ovs_cnt_q <= ovs_next;
              if (at_last) state_q <= ST_DATA;
            end
          end
          ST_DATA: begin
            ovs_cnt_q <= ovs_next;
            if (at_dec) begin
              bit_valid_q <= 1'b1;
              bit_val_q   <= decision;
            end
            if (at_last) begin
              if (bit_cnt_q == LAST_DATA) begin
                state_q   <= ST_STOP;
                bit_cnt_q <= '0;
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_ONE;
              end
            end
          end
          ST_STOP: begin
            if (at_dec) begin
              frame_done_q <= 1'b1;
              frame_err_q  <= ~decision;
              state_q      <= ST_IDLE;
              ovs_cnt_q    <= '0;
            end else begin
              ovs_cnt_q <= ovs_next;
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bit_valid  = bit_valid_q;
  assign bit_val    = bit_val_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign start_err  = start_err_q;
  assign busy       = active;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_rx_oversampler.sv
// Directed bench for uart_rx_oversampler: frames driven bit by bit, recovered
// bits and stop-bit status checked against a scoreboard queue.
`timescale 1ns/1ps
module tb_uart_rx_oversampler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic        rx = 1'b1;
  logic [1:0]  prescale = 2'd1;
  logic [15:0] baud_div = 16'd3;
  logic        tick, bit_valid, bit_val, frame_done, frame_err, start_err, busy;
  logic [1:0]  dbg_state;

`ifdef OVS_MAJORITY_EN
  localparam logic GLITCH_EXP = 1'b1;
`else
  localparam logic GLITCH_EXP = 1'b0;
`endif

  uart_rx_oversampler #(.DIV_W(16), .FRAME_BITS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .prescale   (prescale),
    .baud_div   (baud_div),
    .rx         (rx),
    .tick       (tick),
    .bit_valid  (bit_valid),
    .bit_val    (bit_val),
    .frame_done (frame_done),
    .frame_err  (frame_err),
    .start_err  (start_err),
    .busy       (busy),
    .dbg_state  (dbg_state)
  );

  always #5 clk = ~clk;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   bv_cnt = 0, fd_cnt = 0, se_cnt = 0, tick_cnt = 0;
  logic [0:0] exp_q[$];
  logic [0:0] exp_fe_q[$];
  int   bv_cyc_q[$];

  int   gl_bit = -1, gl_off = 0, gl_len = 0;
  int   abort_bit = -1;
  int   chg_bit = -1;
  logic [1:0] chg_ps = 2'd0;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard side: consume expectations as the DUT strobes.
  always @(negedge clk) begin
    if (tick) tick_cnt++;
    if (bit_valid) begin
      bv_cnt++;
      bv_cyc_q.push_back(cyc);
      if (exp_q.size() == 0) check("bit_valid_unexpected", 32'd1, 32'd0);
      else check("bit_val", {31'd0, bit_val}, {31'd0, exp_q.pop_front()});
    end
    if (frame_done) begin
      fd_cnt++;
      if (exp_fe_q.size() == 0) check("frame_done_unexpected", 32'd1, 32'd0);
      else check("frame_err", {31'd0, frame_err}, {31'd0, exp_fe_q.pop_front()});
    end else if (frame_err) begin
      check("frame_err_without_done", 32'd1, 32'd0);
    end
    if (start_err) se_cnt++;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic hold(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rate(input logic [1:0] ps, input logic [15:0] bd);
    en = 1'b0;
    hold(1);
    prescale = ps;
    baud_div = bd;
    en = 1'b1;
    hold(1);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit, input int cpb);
    for (int i = 0; i < 10; i++) begin
      logic b;
      b = (i == 0) ? 1'b0 : (i == 9) ? stop_bit : data[i-1];
      if (i == chg_bit) prescale = chg_ps;
      rx = b;
      if (i >= 1 && i <= 8 && (i - 1) == abort_bit) begin
        hold(cpb / 4);
        return;
      end
      if (i >= 1 && i <= 8) exp_q.push_back((i - 1 == gl_bit) ? GLITCH_EXP : b);
      if (i == 9) exp_fe_q.push_back(~stop_bit);
      if (i >= 1 && i <= 8 && (i - 1) == gl_bit) begin
        hold(gl_off);
        rx = 1'b0;
        hold(gl_len);
        rx = b;
        hold(cpb - gl_off - gl_len);
      end else begin
        hold(cpb);
      end
    end
    rx = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int i = 0; i < budget && busy; i++) hold(1);
    check("idle_within_budget", {31'd0, busy}, 32'd0);
  endtask

  task automatic check_quiet(input string tag);
    check(tag, {24'd0, tick, bit_valid, bit_val, frame_done, frame_err, start_err, busy, 1'b0} |
               {30'd0, dbg_state}, 32'd0);
  endtask

  task automatic check_spacing(input int n0, input int exp_gap);
    if (bv_cyc_q.size() >= n0 + 8) begin
      for (int k = 1; k < 8; k++)
        check("bit_spacing", bv_cyc_q[n0+k] - bv_cyc_q[n0+k-1], exp_gap);
    end else begin
      check("bit_spacing_count", bv_cyc_q.size() - n0, 8);
    end
  endtask

  task automatic check_frame(input string tag, input int bv0, input int fd0);
    check({tag, "_bits"}, bv_cnt - bv0, 8);
    check({tag, "_frames"}, fd_cnt - fd0, 1);
    check({tag, "_exp_empty"}, exp_q.size(), 0);
    check({tag, "_fe_empty"}, exp_fe_q.size(), 0);
  endtask

  initial begin
    int t0, bv0, fd0, se0, n0;

    // Reset state
    hold(5);
    check_quiet("reset_outputs");
    rst_n = 1'b1;
    hold(2);
    en = 1'b1;
    hold(2);
    check_quiet("idle_after_reset");

    // Divider: baud_div=3 gives one tick per 4 clk, baud_div=0 every clk
    t0 = tick_cnt;
    hold(40);
    check("tick_rate_div3", tick_cnt - t0, 10);
    set_rate(2'd1, 16'd0);
    t0 = tick_cnt;
    hold(16);
    check("tick_rate_div0", tick_cnt - t0, 16);
    set_rate(2'd1, 16'd3);

    // Basic frame 0x55, x16, 64 clk per bit
    bv0 = bv_cnt; fd0 = fd_cnt; n0 = bv_cyc_q.size();
    send_frame(8'h55, 1'b1, 64);
    hold(20);
    check_frame("basic", bv0, fd0);
    check_spacing(n0, 64);

    // False start: 3 ticks low
    bv0 = bv_cnt; se0 = se_cnt;
    rx = 1'b0;
    hold(10);
    check("false_start_busy", {31'd0, busy}, 32'd1);
    hold(2);
    rx = 1'b1;
    wait_idle(200);
    hold(4);
    check("false_start_err", se_cnt - se0, 1);
    check("false_start_no_bits", bv_cnt - bv0, 0);

    // Bad stop bit; the still-low line re-arms START, rejected as a false start
    bv0 = bv_cnt; fd0 = fd_cnt; se0 = se_cnt;
    send_frame(8'h0F, 1'b0, 64);
    hold(100);
    check_frame("bad_stop", bv0, fd0);
    check("bad_stop_restart_err", se_cnt - se0, 1);

    // Glitch at ovs_cnt=N/2 of bit 3, x8
    set_rate(2'd0, 16'd3);
    gl_bit = 3; gl_off = 16; gl_len = 4;
    bv0 = bv_cnt; fd0 = fd_cnt;
    send_frame(8'hFF, 1'b1, 32);
    gl_bit = -1;
    hold(20);
    check_frame("glitch", bv0, fd0);

    // x32 with baud_div=0, prescale changed mid-frame
    set_rate(2'd2, 16'd0);
    chg_bit = 3; chg_ps = 2'd0;
    bv0 = bv_cnt; fd0 = fd_cnt; n0 = bv_cyc_q.size();
    send_frame(8'hA3, 1'b1, 32);
    chg_bit = -1;
    hold(20);
    check_frame("ratio", bv0, fd0);
    check_spacing(n0, 32);

    // Reset at data bit 4, then 0x3C
    set_rate(2'd1, 16'd3);
    abort_bit = 4;
    send_frame(8'h96, 1'b1, 64);
    abort_bit = -1;
    rst_n = 1'b0;
    #2;
    check_quiet("reset_mid_frame");
    check("reset_abort_exp_empty", exp_q.size(), 0);
    rx = 1'b1;
    hold(2);
    rst_n = 1'b1;
    hold(4);
    bv0 = bv_cnt; fd0 = fd_cnt;
    send_frame(8'h3C, 1'b1, 64);
    hold(20);
    check_frame("after_reset", bv0, fd0);

    // en dropped at data bit 4, then 0x3C
    abort_bit = 4;
    bv0 = bv_cnt; fd0 = fd_cnt; se0 = se_cnt;
    send_frame(8'h69, 1'b1, 64);
    abort_bit = -1;
    en = 1'b0;
    hold(2);
    check_quiet("disable_mid_frame");
    rx = 1'b1;
    hold(4);
    check("disable_no_strobes", (fd_cnt - fd0) + (se_cnt - se0), 0);
    check("disable_abort_exp_empty", exp_q.size(), 0);
    en = 1'b1;
    hold(4);
    bv0 = bv_cnt; fd0 = fd_cnt;
    send_frame(8'h3C, 1'b1, 64);
    hold(20);
    check_frame("after_disable", bv0, fd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
